mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 5, meaning log2 of the number of 16-bit words stored (32).
REQ-003 SHALL have clock and reset ports exactly as decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 mem_read  input  1  initiator read request, held until mem_resp.
REQ-007 mem_write  input  1  initiator write request, held until mem_resp.
REQ-008 mem_address  input  lc3b_word  byte address.
REQ-009 mem_wdata  input  lc3b_word  write data.
REQ-010 mem_byte_enable  input  lc3b_mem_wmask  bit0 enables [7:0], bit1 enables [15:8].
REQ-011 mem_resp  output  1  one-cycle completion pulse.
REQ-012 mem_rdata  output  lc3b_word  read data, valid in the mem_resp cycle.
REQ-013 proto_err  output  1  one-cycle pulse on initiator protocol violation.

Function
REQ-014 SHALL implement states IDLE, BUSY, RESP.
REQ-015 In IDLE, exactly one of mem_read/mem_write high: latch op, address, wdata, byte_enable; load counter with LATENCY-1; go to BUSY, or to RESP if LATENCY=1.
REQ-016 In IDLE, mem_read and mem_write both high: no acceptance, proto_err=1 next cycle, stay IDLE.
REQ-017 In BUSY: decrement counter each cycle; at counter 1, go to RESP.
REQ-018 mem_resp SHALL be 1 in exactly the cycle after acceptance + LATENCY-1, i.e. LATENCY cycles after the accepting edge, and 0 otherwise.
REQ-019 In RESP: mem_resp=1; next state IDLE unconditionally.
REQ-020 A request still asserted in IDLE the cycle after RESP SHALL be accepted as a new request (back-to-back, no bubble required of the initiator).
REQ-021 Word index SHALL be latched mem_address[DEPTH_LOG2:1]; bit 0 and bits above DEPTH_LOG2 ignored (addresses alias / wrap modulo 2^(DEPTH_LOG2+1)).
REQ-022 Read: mem_rdata SHALL be registered from array[index] and present in the RESP cycle; it holds its value until the next read response.
REQ-023 Write: array[index] SHALL be updated per latched byte enable at the RESP-cycle edge; mask 00 completes with mem_resp but changes nothing; mem_rdata unchanged.
REQ-024 Read of an index written in the immediately preceding transaction SHALL return the new data.
REQ-025 Request deasserted (both low) during BUSY: abort, no array update, no mem_resp, proto_err pulse, return to IDLE.
REQ-026 mem_address, op or wdata change during BUSY with request still high: proto_err pulse, transaction continues with latched values.
REQ-027 proto_err SHALL be registered, asserted for one cycle per violation event.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, counter 0, mem_resp 0, mem_rdata 16'h0000, proto_err 0, all array words 16'h0000.
REQ-029 Reset mid-transaction SHALL discard it: no write, no mem_resp after release.
REQ-030 First request SHALL be accepted on the first rising edge with reset_n high.

Structure
REQ-031 lc3b_word and lc3b_mem_wmask SHALL come from package lc3b_types; the state enum SHALL be local to the module.
REQ-032 Word array with byte-enable write and registered read SHALL be sub-module responder_array; FSM and counter stay in mem_responder.

Verification
REQ-033 LATENCY=3: write 16'hBEEF to 16'h0010, mask 11 -> mem_resp in 3rd cycle after acceptance; read 16'h0010 -> mem_rdata=16'hBEEF with mem_resp.
REQ-034 Array word 16'h1234 at 16'h0004; write 16'hAB00, mask 10 -> read returns 16'hAB34; mask 00 write of 16'hFFFF -> still 16'hAB34.
REQ-035 Alias: write 16'h5555 to 16'h0042 (DEPTH_LOG2=5) -> read 16'h0002 returns 16'h5555.
REQ-036 Read and write both high in IDLE -> proto_err one cycle, no mem_resp; drop mem_read 1 cycle into BUSY -> proto_err, no mem_resp, no state change of array.
REQ-037 Back-to-back reads to 16'h0000 then 16'h0002 with LATENCY=1 -> mem_resp on two consecutive-transaction cycles separated by one IDLE cycle, correct data each.
REQ-038 reset_n low during BUSY of a write -> array word unchanged (0), mem_resp never pulses, state IDLE after release.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types and the byte-lane merge helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Merge new_word into old_word lane by lane; mask bit0 -> [7:0], bit1 -> [15:8].
  function automatic lc3b_word merge_bytes(input lc3b_word      old_word,
                                           input lc3b_word      new_word,
                                           input lc3b_mem_wmask mask);
    lc3b_word merged;
    merged[7:0]  = mask[0] ? new_word[7:0]  : old_word[7:0];
    merged[15:8] = mask[1] ? new_word[15:8] : old_word[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/responder_array.sv
// Word storage for mem_responder: byte-enabled writes and a registered read port.
module responder_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_index,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_index,
  input  lc3b_word              wr_data,
  input  lc3b_mem_wmask         wr_mask,
  output lc3b_word              rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  lc3b_word words [DEPTH];

  // Storage: cleared on reset, otherwise only the enabled byte lanes of one word change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
    end else if (wr_en) begin
      words[wr_index] <= merge_bytes(words[wr_index], wr_data, wr_mask);
    end
  end

  // Read register: loads only on a read capture, so it holds between read responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= words[rd_index];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for an LC-3b style initiator.
// Requests are held by the initiator until mem_resp; any change or drop of the
// request while the transaction is in flight is reported on proto_err.
module mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 3,  // legal 1..15
  parameter int DEPTH_LOG2 = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output logic          mem_resp,
  output lc3b_word      mem_rdata,
  output logic          proto_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]    state, state_next;
  logic [3:0]    count, count_next;
  logic          perr_next;
  logic          accept;
  logic          lat_write;
  lc3b_word      lat_addr;
  lc3b_word      lat_wdata;
  lc3b_mem_wmask lat_mask;

  logic                  one_req, both_req, no_req, req_changed;
  logic                  arr_rd_en, arr_wr_en;
  logic [DEPTH_LOG2-1:0] arr_rd_index, arr_wr_index;

  assign one_req  = mem_read ^ mem_write;
  assign both_req = mem_read & mem_write;
  assign no_req   = ~(mem_read | mem_write);

  // Any difference from the accepted request while it is still asserted.
  assign req_changed = (mem_address != lat_addr) || (mem_wdata != lat_wdata) ||
                       (mem_write != lat_write) || (mem_read != !lat_write);

  // Next-state, counter and protocol-violation decode.
  always_comb begin
    state_next = state;
    count_next = count;
    perr_next  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (both_req) begin
          perr_next = 1'b1;
        end else if (one_req) begin
          accept     = 1'b1;
          count_next = COUNT_LOAD;
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (no_req) begin
          perr_next  = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end else begin
          perr_next  = req_changed;
          count_next = count - 4'd1;
          if (count == 4'd1) begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // FSM, latency counter and registered protocol-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      proto_err <= perr_next;
    end
  end

  // Request capture at acceptance; later changes are flagged but ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
    end else if (accept) begin
      lat_write <= mem_write;
      lat_addr  <= mem_address;
      lat_wdata <= mem_wdata;
      lat_mask  <= mem_byte_enable;
    end
  end

  // Read data is captured on the edge entering RESP; with LATENCY=1 that is the
  // accepting edge, so the index then comes straight from the bus.
  assign arr_rd_index = (state == IDLE) ? mem_address[DEPTH_LOG2:1] : lat_addr[DEPTH_LOG2:1];
  assign arr_rd_en    = (state_next == RESP) && ((state == IDLE) ? mem_read : !lat_write);
  assign arr_wr_en    = (state == RESP) && lat_write;
  assign arr_wr_index = lat_addr[DEPTH_LOG2:1];

  assign mem_resp = (state == RESP);

  responder_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (arr_rd_en),
    .rd_index (arr_rd_index),
    .wr_en    (arr_wr_en),
    .wr_index (arr_wr_index),
    .wr_data  (lat_wdata),
    .wr_mask  (lat_mask),
    .rdata    (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 uses LATENCY=3, instance 1 LATENCY=1.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  be    [2];
  logic        resp  [2];
  logic [15:0] rdata [2];
  logic        perr  [2];

  typedef struct {
    int          cycle;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int perr_seen [2];
  int perr_exp  [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.LATENCY(3), .DEPTH_LOG2(5)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .mem_read(rd[0]), .mem_write(wr[0]), .mem_address(addr[0]),
    .mem_wdata(wdata[0]), .mem_byte_enable(be[0]),
    .mem_resp(resp[0]), .mem_rdata(rdata[0]), .proto_err(perr[0])
  );

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(5)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .mem_read(rd[1]), .mem_write(wr[1]), .mem_address(addr[1]),
    .mem_wdata(wdata[1]), .mem_byte_enable(be[1]),
    .mem_resp(resp[1]), .mem_rdata(rdata[1]), .proto_err(perr[1])
  );

  function automatic int latency_of(input int id);
    return (id == 0) ? 3 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Drive one request, queue its expected response, wait for mem_resp and
  // return one cycle after the response edge with the request still driven.
  task automatic applyStimulus(input int id, input bit is_write, input logic [15:0] a,
                               input logic [15:0] d, input logic [1:0] m,
                               input logic [15:0] exp_rd);
    exp_t e;
    bit   seen;
    rd[id]    = !is_write;
    wr[id]    = is_write;
    addr[id]  = a;
    wdata[id] = d;
    be[id]    = m;
    e.cycle   = cyc + latency_of(id);
    e.rdata   = exp_rd;
    if (id == 0) sb0.push_back(e);
    else         sb1.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (resp[id]) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL resp_timeout dut%0d addr %0h: got no mem_resp, required one", id, a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus(input int id);
    rd[id] = 1'b0;
    wr[id] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every mem_resp must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (perr[i]) perr_seen[i]++;
      if (resp[i]) begin
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_resp dut%0d: got mem_resp=1 at cycle %0d, required 0", i, cyc);
        end else begin
          if (i == 0) mon_e = sb0.pop_front();
          else        mon_e = sb1.pop_front();
          checkOutput($sformatf("resp_cycle_dut%0d", i), cyc, mon_e.cycle);
          checkOutput($sformatf("resp_rdata_dut%0d", i), {16'h0, rdata[i]}, {16'h0, mon_e.rdata});
        end
      end
    end
  end

  initial begin
    perr_seen = '{0, 0};
    perr_exp  = '{0, 0};
    reset_n   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_resp", {31'h0, resp[0]}, 32'h0);
    checkOutput("reset_rdata", {16'h0, rdata[0]}, 32'h0);
    checkOutput("reset_perr", {31'h0, perr[0]}, 32'h0);
    reset_n = 1'b1;
    $display("[TB] reset released");

    // Full write then read-back.
    applyStimulus(0, 1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
    idleBus(0);
    applyStimulus(0, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);
    idleBus(0);

    // Byte-lane masks.
    applyStimulus(0, 1, 16'h0004, 16'h1234, 2'b11, 16'hBEEF);
    idleBus(0);
    applyStimulus(0, 1, 16'h0004, 16'hAB00, 2'b10, 16'hBEEF);
    idleBus(0);
    applyStimulus(0, 0, 16'h0004, 16'h0000, 2'b00, 16'hAB34);
    idleBus(0);
    applyStimulus(0, 1, 16'h0004, 16'hFFFF, 2'b00, 16'hAB34);
    idleBus(0);
    applyStimulus(0, 0, 16'h0004, 16'h0000, 2'b00, 16'hAB34);
    idleBus(0);
    applyStimulus(0, 1, 16'h0004, 16'h00CD, 2'b01, 16'hAB34);
    idleBus(0);
    applyStimulus(0, 0, 16'h0004, 16'h0000, 2'b00, 16'hABCD);
    idleBus(0);

    // Address aliasing: 0x0042, 0x0002 and 0x0003 all hit word 1.
    applyStimulus(0, 1, 16'h0042, 16'h5555, 2'b11, 16'hABCD);
    idleBus(0);
    applyStimulus(0, 0, 16'h0002, 16'h0000, 2'b00, 16'h5555);
    idleBus(0);
    applyStimulus(0, 0, 16'h0003, 16'h0000, 2'b00, 16'h5555);
    idleBus(0);

    // Read and write together in IDLE.
    $display("[TB] protocol: read and write together");
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0010;
    @(posedge clk); #1;
    rd[0] = 1'b0; wr[0] = 1'b0;
    perr_exp[0]++;
    @(negedge clk);
    checkOutput("perr_both_high", {31'h0, perr[0]}, 32'h1);
    @(negedge clk);
    checkOutput("perr_both_high_single", {31'h0, perr[0]}, 32'h0);
    @(posedge clk); #1;

    // Read dropped one cycle into BUSY.
    $display("[TB] protocol: read aborted");
    rd[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'h0000;
    @(posedge clk); #1;
    rd[0] = 1'b0;
    @(posedge clk); #1;
    perr_exp[0]++;
    @(negedge clk);
    checkOutput("perr_read_abort", {31'h0, perr[0]}, 32'h1);
    @(posedge clk); #1;

    // Write dropped one cycle into BUSY must leave the word alone.
    wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'hDEAD; be[0] = 2'b11;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(posedge clk); #1;
    perr_exp[0]++;
    @(negedge clk);
    checkOutput("perr_write_abort", {31'h0, perr[0]}, 32'h1);
    @(posedge clk); #1;
    applyStimulus(0, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);
    idleBus(0);

    // Address wiggle during BUSY: flagged, transaction uses the latched address.
    $display("[TB] protocol: address change in flight");
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0004; wdata[0] = 16'h0000; be[0] = 2'b00;
    mon_e.cycle = cyc + 3;
    mon_e.rdata = 16'hABCD;
    sb0.push_back(mon_e);
    @(posedge clk); #1;
    addr[0] = 16'h0006;
    @(posedge clk); #1;
    addr[0] = 16'h0004;
    perr_exp[0]++;
    @(negedge clk);
    checkOutput("perr_addr_change", {31'h0, perr[0]}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idleBus(0);

    // Write immediately followed by a read of the same word, no bubble.
    applyStimulus(0, 1, 16'h0008, 16'h7777, 2'b11, 16'hABCD);
    applyStimulus(0, 0, 16'h0008, 16'h0000, 2'b00, 16'h7777);
    idleBus(0);

    // LATENCY=1 instance: back-to-back reads one IDLE cycle apart.
    applyStimulus(1, 1, 16'h0000, 16'hA1A1, 2'b11, 16'h0000);
    idleBus(1);
    applyStimulus(1, 1, 16'h0002, 16'hB2B2, 2'b11, 16'h0000);
    idleBus(1);
    applyStimulus(1, 0, 16'h0000, 16'h0000, 2'b00, 16'hA1A1);
    applyStimulus(1, 0, 16'h0002, 16'h0000, 2'b00, 16'hB2B2);
    idleBus(1);

    // Reset in the middle of a write.
    $display("[TB] reset during write");
    wr[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0020; wdata[0] = 16'h1234; be[0] = 2'b11;
    @(posedge clk); #1;
    reset_n = 1'b0;
    wr[0] = 1'b0;
    #1;
    checkOutput("reset_mid_resp", {31'h0, resp[0]}, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("reset_mid_rdata0", {16'h0, rdata[0]}, 32'h0);
    checkOutput("reset_mid_rdata1", {16'h0, rdata[1]}, 32'h0);
    applyStimulus(0, 0, 16'h0020, 16'h0000, 2'b00, 16'h0000);
    idleBus(0);
    applyStimulus(0, 0, 16'h0010, 16'h0000, 2'b00, 16'h0000);
    idleBus(0);
    applyStimulus(1, 0, 16'h0002, 16'h0000, 2'b00, 16'h0000);
    idleBus(1);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("sb0_drained", sb0.size(), 32'h0);
    checkOutput("sb1_drained", sb1.size(), 32'h0);
    checkOutput("perr_count_dut0", perr_seen[0], perr_exp[0]);
    checkOutput("perr_count_dut1", perr_seen[1], perr_exp[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
